store_checker: RTL and testbench

STORE_CHECKER -- requirements
Module: store_checker

---
 rtl/store_checker.sv | 144 ++++++++++++++
 tb/tb_store_checker.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/store_checker.sv
// Store checker: compares processor data-memory writes against a preloaded table
// of expected {address, data} stores and reports pass, mismatch or timeout.
module store_checker #(
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int WE_W    = 2,
    parameter int ORDERED = 1,
    parameter int TIMEOUT = 1000,
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WE_W-1:0]   memwrite,
    input  logic [ADDR_W-1:0] dataadr,
    input  logic [DATA_W-1:0] writedata,
    input  logic              exp_wr,
    input  logic [IDX_W-1:0]  exp_idx,
    input  logic [ADDR_W-1:0] exp_addr,
    input  logic [DATA_W-1:0] exp_data,
    input  logic [CNT_W-1:0]  num_exp,
    input  logic              start,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [1:0]        fail_code,
    output logic [CNT_W-1:0]  match_cnt,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [31:0]       cyc_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   idx_reg;
    logic [CNT_W-1:0]   num_reg;
    logic [CNT_W-1:0]   match_cnt_reg;
    logic [31:0]        cyc_cnt_reg;
    logic [1:0]         fail_code_reg;
    logic [ADDR_W-1:0]  fail_addr_reg;
    logic [DATA_W-1:0]  fail_data_reg;

    logic [ADDR_W-1:0]  tab_addr [DEPTH];
    logic [DATA_W-1:0]  tab_data [DEPTH];
    logic               tab_we;
    logic [CNT_W-1:0]   num_clamped;
    logic               wr_seen, hit, final_hit, miss, timeout;

    assign tab_we = (state_reg == S_IDLE) && exp_wr;

    // Table lives in flops: it must clear on reset and be read combinationally.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [ADDR_W-1:0] addr_reg;
            logic [DATA_W-1:0] data_reg;
            always_ff @(posedge clk) begin
                if (!reset) begin
                    addr_reg <= '0;
                    data_reg <= '0;
                end else if (tab_we && (exp_idx == IDX_W'(gi))) begin
                    addr_reg <= exp_addr;
                    data_reg <= exp_data;
                end
            end
            assign tab_addr[gi] = addr_reg;
            assign tab_data[gi] = data_reg;
        end
    endgenerate

    assign num_clamped = (num_exp > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : num_exp;

    always_comb begin
        state_next = state_reg;
        wr_seen    = |memwrite;
        hit        = wr_seen && (dataadr == tab_addr[idx_reg]) && (writedata == tab_data[idx_reg]);
        final_hit  = hit && (match_cnt_reg == num_reg - CNT_W'(1));
        miss       = wr_seen && !hit && (ORDERED != 0);
        timeout    = (cyc_cnt_reg == 32'(TIMEOUT - 1));
        case (state_reg)
            S_RUN: begin
                // A completing match beats both a timeout and any later check.
                if (final_hit)    state_next = S_PASS;
                else if (miss)    state_next = S_FAIL;
                else if (timeout) state_next = S_FAIL;
            end
            default: begin
                if (start) state_next = (num_clamped == '0) ? S_PASS : S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            idx_reg       <= '0;
            num_reg       <= '0;
            match_cnt_reg <= '0;
            cyc_cnt_reg   <= '0;
            fail_code_reg <= 2'b00;
            fail_addr_reg <= '0;
            fail_data_reg <= '0;
        end else if (state_reg == S_RUN) begin
            if (cyc_cnt_reg != '1) cyc_cnt_reg <= cyc_cnt_reg + 32'd1;
            if (hit) begin
                idx_reg       <= idx_reg + IDX_W'(1);
                match_cnt_reg <= match_cnt_reg + CNT_W'(1);
                if (!final_hit && timeout) fail_code_reg <= 2'b10;
            end else if (miss) begin
                fail_code_reg <= 2'b01;
                fail_addr_reg <= dataadr;
                fail_data_reg <= writedata;
            end else if (timeout) begin
                fail_code_reg <= 2'b10;
            end
        end else if (start) begin
            idx_reg       <= '0;
            num_reg       <= num_clamped;
            match_cnt_reg <= '0;
            cyc_cnt_reg   <= '0;
            fail_code_reg <= 2'b00;
            fail_addr_reg <= '0;
            fail_data_reg <= '0;
        end
    end

    assign done      = (state_reg == S_PASS) || (state_reg == S_FAIL);
    assign pass      = (state_reg == S_PASS);
    assign fail      = (state_reg == S_FAIL);
    assign fail_code = fail_code_reg;
    assign match_cnt = match_cnt_reg;
    assign fail_addr = fail_addr_reg;
    assign fail_data = fail_data_reg;
    assign cyc_cnt   = cyc_cnt_reg;

endmodule

// File: tb/tb_store_checker.sv
// Directed bench for store_checker: an ORDERED=1 and an ORDERED=0 instance
// share stimulus; both use TIMEOUT=20.
module tb_store_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  memwrite;
    logic [31:0] dataadr, writedata;
    logic        exp_wr;
    logic [2:0]  exp_idx;
    logic [31:0] exp_addr, exp_data;
    logic [3:0]  num_exp;
    logic        start;

    logic        a_done, a_pass, a_fail, b_done, b_pass, b_fail;
    logic [1:0]  a_code, b_code;
    logic [3:0]  a_match, b_match;
    logic [31:0] a_faddr, a_fdata, b_faddr, b_fdata, a_cyc, b_cyc;

    int tests_run = 0;
    int failures  = 0;

    always #5 clk = ~clk;

    store_checker #(.DEPTH(8), .ADDR_W(32), .DATA_W(32), .WE_W(2), .ORDERED(1), .TIMEOUT(20)) dut_a (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
        .exp_wr(exp_wr), .exp_idx(exp_idx), .exp_addr(exp_addr), .exp_data(exp_data),
        .num_exp(num_exp), .start(start), .done(a_done), .pass(a_pass), .fail(a_fail),
        .fail_code(a_code), .match_cnt(a_match), .fail_addr(a_faddr), .fail_data(a_fdata),
        .cyc_cnt(a_cyc));

    store_checker #(.DEPTH(8), .ADDR_W(32), .DATA_W(32), .WE_W(2), .ORDERED(0), .TIMEOUT(20)) dut_b (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
        .exp_wr(exp_wr), .exp_idx(exp_idx), .exp_addr(exp_addr), .exp_data(exp_data),
        .num_exp(num_exp), .start(start), .done(b_done), .pass(b_pass), .fail(b_fail),
        .fail_code(b_code), .match_cnt(b_match), .fail_addr(b_faddr), .fail_data(b_fdata),
        .cyc_cnt(b_cyc));

    // Inputs change on the falling edge; outputs are read on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0; tick(); reset = 1'b1;
        $display("[TB] reset");
    endtask

    task automatic load(input logic [2:0] i, input logic [31:0] a, input logic [31:0] d);
        exp_wr = 1'b1; exp_idx = i; exp_addr = a; exp_data = d;
        tick();
        exp_wr = 1'b0;
        $display("[TB] load idx=%0d addr=%0d data=%h", i, a, d);
    endtask

    task automatic start_run(input logic [3:0] n);
        num_exp = n; start = 1'b1;
        tick();
        start = 1'b0;
        $display("[TB] start num_exp=%0d", n);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        memwrite = 2'b01; dataadr = a; writedata = d;
        tick();
        memwrite = 2'b00;
        $display("[TB] store addr=%0d data=%h", a, d);
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b1; exp_wr = 1'b1; exp_idx = 3'd0; exp_addr = 32'd7; exp_data = 32'd7;
        tick();
        start = 1'b0; exp_wr = 1'b0; reset = 1'b1;
        tick();
        $display("[TB] reset with start/exp_wr asserted");
        tests_run++;
        if ({a_done, a_pass, a_fail, a_code, a_match} !== 9'b0 || a_cyc !== 32'd0 || a_faddr !== 32'd0) begin
            failures++;
            $display("FAIL reset_state: done=%b pass=%b fail=%b code=%b match=%0d cyc=%0d required all zero",
                     a_done, a_pass, a_fail, a_code, a_match, a_cyc);
        end
        // Entry 0 must still be zero: exp_wr lost to reset.
        start_run(4'd1);
        store(32'd0, 32'd0);
        tests_run++;
        if (a_pass !== 1'b1) begin
            failures++;
            $display("FAIL reset_table_zero: pass=%b required 1", a_pass);
        end
    endtask

    task automatic test_single();
        do_reset();
        load(3'd0, 32'd84, 32'h41800888);
        start_run(4'd1);
        memwrite = 2'b00; dataadr = 32'd84; writedata = 32'h41800888;
        tick();
        $display("[TB] idle bus with matching addr/data, memwrite=0");
        tests_run++;
        if (a_done !== 1'b0 || a_match !== 4'd0 || a_cyc !== 32'd1) begin
            failures++;
            $display("FAIL no_strobe: done=%b match=%0d cyc=%0d required done=0 match=0 cyc=1", a_done, a_match, a_cyc);
        end
        store(32'd84, 32'h41800888);
        tests_run++;
        if ({a_done, a_pass, a_fail, a_code} !== 5'b11000 || a_match !== 4'd1) begin
            failures++;
            $display("FAIL single_pass: done=%b pass=%b fail=%b code=%b match=%0d required 1 1 0 00 1",
                     a_done, a_pass, a_fail, a_code, a_match);
        end
    endtask

    task automatic test_ordering();
        do_reset();
        load(3'd0, 32'd80, 32'd1);
        load(3'd1, 32'd84, 32'd2);
        start_run(4'd2);
        store(32'd80, 32'd1);
        tests_run++;
        if (a_match !== 4'd1 || b_match !== 4'd1 || a_done !== 1'b0) begin
            failures++;
            $display("FAIL first_match: a_match=%0d b_match=%0d a_done=%b required 1 1 0", a_match, b_match, a_done);
        end
        store(32'd88, 32'd5);
        tests_run++;
        if ({a_done, a_pass, a_fail, a_code} !== 5'b10101 || a_faddr !== 32'd88 || a_fdata !== 32'd5 || a_match !== 4'd1) begin
            failures++;
            $display("FAIL ordered_mismatch: done=%b pass=%b fail=%b code=%b addr=%0d data=%0d match=%0d required 1 0 1 01 88 5 1",
                     a_done, a_pass, a_fail, a_code, a_faddr, a_fdata, a_match);
        end
        tests_run++;
        if (b_done !== 1'b0 || b_match !== 4'd1) begin
            failures++;
            $display("FAIL unordered_ignore: done=%b match=%0d required 0 1", b_done, b_match);
        end
        store(32'd84, 32'd2);
        tests_run++;
        if ({b_done, b_pass, b_fail, b_code} !== 5'b11000 || b_match !== 4'd2) begin
            failures++;
            $display("FAIL unordered_pass: done=%b pass=%b fail=%b code=%b match=%0d required 1 1 0 00 2",
                     b_done, b_pass, b_fail, b_code, b_match);
        end
        tests_run++;
        if ({a_fail, a_code} !== 3'b101 || a_faddr !== 32'd88 || a_match !== 4'd1) begin
            failures++;
            $display("FAIL fail_hold: fail=%b code=%b addr=%0d match=%0d required 1 01 88 1", a_fail, a_code, a_faddr, a_match);
        end
    endtask

    task automatic test_timeout();
        start_run(4'd1);
        for (int i = 0; i < 19; i++) tick();
        $display("[TB] 19 idle RUN cycles");
        tests_run++;
        if (a_done !== 1'b0 || a_cyc !== 32'd19) begin
            failures++;
            $display("FAIL pre_timeout: done=%b cyc=%0d required 0 19", a_done, a_cyc);
        end
        tick();
        $display("[TB] 20th RUN cycle");
        tests_run++;
        if ({a_done, a_pass, a_fail, a_code} !== 5'b10110 || a_cyc !== 32'd20) begin
            failures++;
            $display("FAIL timeout: done=%b pass=%b fail=%b code=%b cyc=%0d required 1 0 1 10 20",
                     a_done, a_pass, a_fail, a_code, a_cyc);
        end
        tick();
        tests_run++;
        if (a_cyc !== 32'd20 || a_fail !== 1'b1 || a_code !== 2'b10) begin
            failures++;
            $display("FAIL timeout_hold: cyc=%0d fail=%b code=%b required 20 1 10", a_cyc, a_fail, a_code);
        end
    endtask

    task automatic test_timeout_match();
        start_run(4'd1);
        for (int i = 0; i < 19; i++) tick();
        store(32'd80, 32'd1);
        tests_run++;
        if ({a_pass, a_fail, a_code} !== 4'b1000 || a_cyc !== 32'd20 || a_match !== 4'd1) begin
            failures++;
            $display("FAIL match_on_timeout: pass=%b fail=%b code=%b cyc=%0d match=%0d required 1 0 00 20 1",
                     a_pass, a_fail, a_code, a_cyc, a_match);
        end
    endtask

    task automatic test_zero();
        start_run(4'd0);
        tests_run++;
        if ({a_done, a_pass, a_fail} !== 3'b110 || a_match !== 4'd0 || a_cyc !== 32'd0) begin
            failures++;
            $display("FAIL zero_entries: done=%b pass=%b fail=%b match=%0d cyc=%0d required 1 1 0 0 0",
                     a_done, a_pass, a_fail, a_match, a_cyc);
        end
    endtask

    task automatic test_reset_mid();
        start_run(4'd2);
        store(32'd80, 32'd1);
        start_run(4'd2);
        tests_run++;
        if (a_match !== 4'd1 || a_cyc !== 32'd2 || a_done !== 1'b0) begin
            failures++;
            $display("FAIL start_in_run: match=%0d cyc=%0d done=%b required 1 2 0", a_match, a_cyc, a_done);
        end
        do_reset();
        tests_run++;
        if (a_match !== 4'd0 || a_done !== 1'b0 || a_cyc !== 32'd0) begin
            failures++;
            $display("FAIL mid_run_reset: match=%0d done=%b cyc=%0d required 0 0 0", a_match, a_done, a_cyc);
        end
        load(3'd0, 32'd80, 32'd1);
        start_run(4'd1);
        load(3'd0, 32'd99, 32'd99);
        store(32'd80, 32'd1);
        tests_run++;
        if (a_pass !== 1'b1) begin
            failures++;
            $display("FAIL exp_wr_in_run: pass=%b required 1", a_pass);
        end
        start_run(4'd1);
        store(32'd80, 32'd1);
        tests_run++;
        if (a_pass !== 1'b1 || a_match !== 4'd1) begin
            failures++;
            $display("FAIL rerun: pass=%b match=%0d required 1 1", a_pass, a_match);
        end
    endtask

    initial begin
        reset = 1'b1; memwrite = 2'b00; dataadr = '0; writedata = '0;
        exp_wr = 1'b0; exp_idx = '0; exp_addr = '0; exp_data = '0; num_exp = '0; start = 1'b0;
        tick();
        test_reset();
        test_single();
        test_ordering();
        test_timeout();
        test_timeout_match();
        test_zero();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
